// File: rtl/mips_pkg.sv
// Shared MIPS-subset definitions: opcode/funct constants, NOP word,
// fetch-unit FSM states and instruction encoding helpers.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b000001;
    localparam logic [5:0] OP_SW    = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000011;
    localparam logic [5:0] OP_J     = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SUBI  = 6'b001001;

    localparam logic [5:0] FU_AND = 6'b000000;
    localparam logic [5:0] FU_OR  = 6'b000001;
    localparam logic [5:0] FU_ADD = 6'b000010;
    localparam logic [5:0] FU_SUB = 6'b000110;
    localparam logic [5:0] FU_SLT = 6'b000111;
    localparam logic [5:0] FU_NOR = 6'b001100;

    localparam logic [31:0] NOP_WORD = 32'h0;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2
    } fetch_state_t;

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {OP_RTYPE, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] target);
        return {op, target};
    endfunction

endpackage

// File: rtl/imem_fetch_unit_bank.sv
// Instruction storage: one synchronous write port, one registered read port.
// The array itself is never reset; the read register holds when not enabled.
module imem_bank #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 32,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/imem_fetch_unit.sv
// Loadable instruction memory: streams a program in over the load port, then
// serves 1-cycle-latency fetches with alignment and loaded-length checking.
module imem_fetch_unit
    import mips_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int ADDR_W = 32,
    parameter  int DEPTH  = 32,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_done,
    output logic              load_ovf,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic              ins_valid,
    output logic [DATA_W-1:0] ins,
    output logic              fetch_fault,
    output logic [IDX_W:0]    prog_len
);

    localparam logic [IDX_W:0] DEPTH_CNT = (IDX_W + 1)'(DEPTH);
    localparam logic [IDX_W:0] CNT_ONE   = (IDX_W + 1)'(1);

    fetch_state_t      state, state_next;
    logic [IDX_W:0]    wr_idx;
    logic              wr_full;
    logic              take_word;
    logic              load_end;
    logic              accept;
    logic              misaligned;
    logic              beyond;
    logic              fault;
    logic [ADDR_W-1:0] word_addr;
    logic              use_nop;
    logic [DATA_W-1:0] bank_rdata;

    assign wr_full    = (wr_idx == DEPTH_CNT);
    assign take_word  = (state == S_LOAD) && load_valid && !load_start;
    assign load_end   = take_word && load_last;
    assign accept     = fetch_req && fetch_ready;
    assign word_addr  = fetch_addr >> 2;
    assign misaligned = |fetch_addr[1:0];
    // Full word address is compared so out-of-range addresses never alias.
    assign beyond     = (word_addr >= ADDR_W'(prog_len));
    assign fault      = misaligned || beyond;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_EMPTY: if (load_start) state_next = S_LOAD;
            S_LOAD:  if (load_end)   state_next = S_RUN;
            S_RUN:   if (load_start) state_next = S_LOAD;
            default:                 state_next = S_EMPTY;
        endcase
    end

    always_comb begin
        fetch_ready = (state == S_RUN) && !load_start;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_idx    <= '0;
            prog_len  <= '0;
            load_ovf  <= 1'b0;
            load_done <= 1'b0;
        end else begin
            load_done <= load_end;
            if (load_start) begin
                wr_idx   <= '0;
                load_ovf <= 1'b0;
            end else if (take_word) begin
                if (wr_full) begin
                    load_ovf <= 1'b1;
                end else begin
                    wr_idx <= wr_idx + CNT_ONE;
                end
                if (load_last) begin
                    prog_len <= wr_full ? DEPTH_CNT : wr_idx + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ins_valid   <= 1'b0;
            fetch_fault <= 1'b0;
            use_nop     <= 1'b1;
        end else begin
            ins_valid <= accept;
            if (accept) begin
                fetch_fault <= fault;
                use_nop     <= fault;
            end
        end
    end

    // The bank read register has no reset, so a flag selects NOP until a good fetch lands.
    always_comb begin
        ins = use_nop ? DATA_W'(NOP_WORD) : bank_rdata;
    end

    imem_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_bank (
        .clk   (clk),
        .we    (take_word && !wr_full),
        .waddr (wr_idx[IDX_W-1:0]),
        .wdata (load_data),
        .re    (accept && !fault),
        .raddr (fetch_addr[IDX_W+1:2]),
        .rdata (bank_rdata)
    );

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Scoreboard bench for imem_fetch_unit: a DEPTH=32 and a DEPTH=4 instance,
// randomized loads/fetches checked against a word-array reference model.
module tb_imem_fetch_unit;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        load_start [2];
    logic        load_valid [2];
    logic        load_last  [2];
    logic        fetch_req  [2];
    logic [31:0] load_data  [2];
    logic [31:0] fetch_addr [2];

    logic        load_done0, load_done1, load_ovf0, load_ovf1;
    logic        fetch_ready0, fetch_ready1, ins_valid0, ins_valid1;
    logic        fetch_fault0, fetch_fault1;
    logic [31:0] ins0, ins1;
    logic [5:0]  prog_len0;
    logic [2:0]  prog_len1;

    imem_fetch_unit #(.DATA_W(32), .ADDR_W(32), .DEPTH(32)) dut0 (
        .clk(clk), .rst(rst),
        .load_start(load_start[0]), .load_valid(load_valid[0]), .load_data(load_data[0]),
        .load_last(load_last[0]), .load_done(load_done0), .load_ovf(load_ovf0),
        .fetch_req(fetch_req[0]), .fetch_addr(fetch_addr[0]), .fetch_ready(fetch_ready0),
        .ins_valid(ins_valid0), .ins(ins0), .fetch_fault(fetch_fault0), .prog_len(prog_len0)
    );

    imem_fetch_unit #(.DATA_W(32), .ADDR_W(32), .DEPTH(4)) dut1 (
        .clk(clk), .rst(rst),
        .load_start(load_start[1]), .load_valid(load_valid[1]), .load_data(load_data[1]),
        .load_last(load_last[1]), .load_done(load_done1), .load_ovf(load_ovf1),
        .fetch_req(fetch_req[1]), .fetch_addr(fetch_addr[1]), .fetch_ready(fetch_ready1),
        .ins_valid(ins_valid1), .ins(ins1), .fetch_fault(fetch_fault1), .prog_len(prog_len1)
    );

    logic [1:0]  done_a, ovf_a, ready_a, valid_a, fault_a;
    logic [31:0] ins_a [2];
    int          plen_a [2];
    assign done_a  = {load_done1, load_done0};
    assign ovf_a   = {load_ovf1, load_ovf0};
    assign ready_a = {fetch_ready1, fetch_ready0};
    assign valid_a = {ins_valid1, ins_valid0};
    assign fault_a = {fetch_fault1, fetch_fault0};
    assign ins_a[0]  = ins0;
    assign ins_a[1]  = ins1;
    assign plen_a[0] = int'(prog_len0);
    assign plen_a[1] = int'(prog_len1);

    // Reference model: stored words, loaded length, load cursor, phase (0 empty, 1 loading, 2 running).
    typedef struct {
        logic [31:0] ins;
        logic        fault;
    } exp_t;

    logic [31:0] mem_m [2][32];
    int          plen_m  [2];
    int          wr_m    [2];
    int          st_m    [2];
    int          depth_m [2];
    logic        ovf_m   [2];
    exp_t        q0[$];
    exp_t        q1[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t model_fetch(input int u, input logic [31:0] addr);
        exp_t        e;
        int unsigned w;
        w = addr >> 2;
        e.fault = (addr[1:0] != 2'b00) || (w >= $unsigned(plen_m[u]));
        if (e.fault) e.ins = NOP_WORD;
        else         e.ins = mem_m[u][w];
        return e;
    endfunction

    // Monitor: every presented result must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        for (int u = 0; u < 2; u++) begin
            if (!rst && valid_a[u]) begin
                if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ins_valid u=%0d actual=1 required=0 t=%0t", u, $time);
                end else begin
                    if (u == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    chk("fetch_ins", ins_a[u], e.ins);
                    chk1("fetch_fault", fault_a[u], e.fault);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int u);
        load_start[u] = 1'b0;
        load_valid[u] = 1'b0;
        load_last[u]  = 1'b0;
        fetch_req[u]  = 1'b0;
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            st_m[u] = 0; plen_m[u] = 0; wr_m[u] = 0; ovf_m[u] = 1'b0;
        end
    endtask

    task automatic start_load(input int u);
        load_start[u] = 1'b1;
        #1;
        chk1("ready_during_load_start", ready_a[u], 1'b0);
        step();
        load_start[u] = 1'b0;
        st_m[u] = 1; wr_m[u] = 0; ovf_m[u] = 1'b0;
    endtask

    task automatic load_word(input int u, input logic [31:0] data, input logic last);
        load_valid[u] = 1'b1;
        load_data[u]  = data;
        load_last[u]  = last;
        #1;
        chk1("ready_in_load", ready_a[u], 1'b0);
        step();
        load_valid[u] = 1'b0;
        load_last[u]  = 1'b0;
        if (wr_m[u] < depth_m[u]) begin
            mem_m[u][wr_m[u]] = data;
            wr_m[u]++;
        end else begin
            ovf_m[u] = 1'b1;
        end
        if (last) begin
            plen_m[u] = wr_m[u];
            st_m[u]   = 2;
        end
        chk1("load_done", done_a[u], last);
        if (last) begin
            step();
            chk1("load_done_clear", done_a[u], 1'b0);
            chk("prog_len", plen_a[u], plen_m[u]);
            chk1("load_ovf", ovf_a[u], ovf_m[u]);
        end
    endtask

    task automatic load_rand(input int u, input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) step();
            load_word(u, $urandom | 32'h1, i == n - 1);
        end
    endtask

    task automatic fetch(input int u, input logic [31:0] addr);
        logic exp_ready;
        fetch_req[u]  = 1'b1;
        fetch_addr[u] = addr;
        #1;
        exp_ready = (st_m[u] == 2) && !load_start[u];
        chk1("fetch_ready", ready_a[u], exp_ready);
        if (exp_ready) begin
            if (u == 0) q0.push_back(model_fetch(u, addr));
            else        q1.push_back(model_fetch(u, addr));
        end
        step();
        fetch_req[u] = 1'b0;
    endtask

    task automatic fetch_rand(input int u, input int n);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 3))
                0:       a = 32'($urandom_range(0, depth_m[u] + 2)) << 2;
                1:       a = (32'($urandom_range(0, depth_m[u])) << 2) | 32'($urandom_range(1, 3));
                2:       a = $urandom;
                default: a = 32'($urandom_range(0, (plen_m[u] > 0) ? plen_m[u] - 1 : 0)) << 2;
            endcase
            fetch(u, a);
            if ($urandom_range(0, 3) == 0) step();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] prog [11];

    initial begin
        depth_m[0] = 32;
        depth_m[1] = 4;
        model_reset();
        for (int u = 0; u < 2; u++) begin
            idle(u);
            load_data[u]  = '0;
            fetch_addr[u] = '0;
        end
        prog[0]  = enc_r(5'd4, 5'd8, 5'd10, FU_ADD);
        prog[1]  = enc_r(5'd10, 5'd4, 5'd11, FU_SUB);
        prog[2]  = enc_r(5'd10, 5'd11, 5'd12, FU_AND);
        prog[3]  = enc_r(5'd12, 5'd4, 5'd13, FU_OR);
        prog[4]  = enc_r(5'd4, 5'd8, 5'd14, FU_SLT);
        prog[5]  = enc_r(5'd4, 5'd8, 5'd15, FU_NOR);
        prog[6]  = enc_i(OP_LW, 5'd0, 5'd9, 16'd4);
        prog[7]  = enc_i(OP_SW, 5'd0, 5'd9, 16'd8);
        prog[8]  = enc_i(OP_ADDI, 5'd5, 5'd5, 16'd1);
        prog[9]  = enc_i(OP_BEQ, 5'd5, 5'd6, 16'hFFFE);
        prog[10] = enc_j(OP_J, 26'd0);

        // Reset values, then fetch refused while empty
        #2;
        chk("reset_prog_len", plen_a[0], 0);
        chk1("reset_ins_valid", valid_a[0], 1'b0);
        chk("reset_ins", ins_a[0], 32'h0);
        chk1("reset_ready", ready_a[0], 1'b0);
        step();
        rst = 1'b0;
        fetch(0, 32'h0);
        chk1("empty_no_ins_valid", valid_a[0], 1'b0);
        chk("empty_prog_len", plen_a[0], 0);

        // 11-word program, back-to-back fetch of every word, then hold check
        start_load(0);
        for (int i = 0; i < 11; i++) begin
            repeat ($urandom_range(0, 2)) step();
            load_word(0, prog[i], i == 10);
        end
        for (int i = 0; i < 11; i++) fetch(0, 32'(i) << 2);
        step();
        step();
        chk("ins_holds", ins_a[0], prog[10]);
        fetch_rand(0, 20);

        // 4-word program, fault cases
        start_load(0);
        load_rand(0, 4);
        fetch(0, 32'h10);
        fetch(0, 32'h6);
        fetch(0, 32'h80);
        for (int i = 0; i < 4; i++) fetch(0, 32'(i) << 2);
        fetch_rand(0, 12);

        // DEPTH=4 overflow: 6 words offered
        start_load(1);
        load_rand(1, 6);
        for (int i = 0; i < 5; i++) fetch(1, 32'(i) << 2);
        fetch_rand(1, 12);

        // load_start and fetch_req together in RUN: load wins
        load_start[0] = 1'b1;
        fetch_req[0]  = 1'b1;
        fetch_addr[0] = 32'h0;
        #1;
        chk1("collide_ready", ready_a[0], 1'b0);
        step();
        idle(0);
        st_m[0] = 1; wr_m[0] = 0; ovf_m[0] = 1'b0;
        chk1("collide_no_ins_valid", valid_a[0], 1'b0);
        fetch(0, 32'h4);
        load_rand(0, 6);
        fetch_rand(0, 10);

        // Randomized rounds on both instances
        for (int r = 0; r < 8; r++) begin
            int u;
            u = r % 2;
            start_load(u);
            load_rand(u, $urandom_range(1, depth_m[u] + 2));
            fetch_rand(u, 15);
        end

        // Asynchronous reset in the middle of a load
        fetch(0, 32'h0);
        step();
        start_load(0);
        for (int i = 0; i < 3; i++) load_word(0, $urandom | 32'h1, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        chk("midload_rst_prog_len", plen_a[0], 0);
        chk1("midload_rst_ovf", ovf_a[0], 1'b0);
        chk1("midload_rst_done", done_a[0], 1'b0);
        chk1("midload_rst_ins_valid", valid_a[0], 1'b0);
        chk("midload_rst_ins", ins_a[0], 32'h0);
        chk1("midload_rst_fault", fault_a[0], 1'b0);
        chk1("midload_rst_ready", ready_a[0], 1'b0);
        chk("midload_rst_prog_len1", plen_a[1], 0);
        step();
        rst = 1'b0;
        fetch(0, 32'h0);
        load_word(0, 32'h1234_5679, 1'b0);
        fetch(0, 32'h0);
        start_load(0);
        load_rand(0, 5);
        fetch_rand(0, 10);

        step();
        step();
        step();
        chk("scoreboard_drained", 32'(q0.size() + q1.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
